// File: rtl/pipe_gap_scheduler.sv
// pipe_gap_scheduler: paces pipe spawns off frame ticks and draws a gap row
// from the external LFSR. Out-of-range draws are retried a bounded number of
// times, then clamped. Finished gap rows queue in a 4-deep first-word-fall-through
// FIFO for the pipe renderer.
`timescale 1ns/1ps
module pipe_gap_scheduler #(
  parameter int SPAWN_FRAMES = 60,
  parameter int GAP_MIN      = 2,
  parameter int GAP_MAX      = 25,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_run,
  input  logic       frame_tick,
  input  logic [4:0] lfsr_data,
  output logic       lfsr_step,
  output logic       gap_valid,
  input  logic       gap_ready,
  output logic [4:0] gap_y,
  output logic [2:0] gap_count,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] DRAW  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] PUSH  = 3'd4;

  localparam int         DEPTH      = 4;
  localparam logic [7:0] LAST_FRAME = 8'(SPAWN_FRAMES - 1);
  localparam logic [7:0] RETRY_LIM  = 8'(MAX_RETRY);
  localparam logic [4:0] GMIN       = 5'(GAP_MIN);
  localparam logic [4:0] GMAX       = 5'(GAP_MAX);
  localparam logic [2:0] FULL_CNT   = 3'(DEPTH);

  logic [2:0]            state;
  logic [7:0]            frame_cnt;
  logic [7:0]            retry_cnt;
  logic [4:0]            gap_lat;
  logic [DEPTH-1:0][4:0] mem;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [4:0]            y_hold;
  logic                  in_range;
  logic                  push_en;
  logic                  pop;
  logic                  push_ok;
  logic                  drop_evt;

  assign in_range  = (lfsr_data >= GMIN) && (lfsr_data <= GMAX);
  assign lfsr_step = (state == DRAW);
  assign gap_valid = (gap_count != 3'd0);
  // Head is shown straight from storage; when empty, the last shown head is held.
  assign gap_y     = gap_valid ? mem[rd_ptr] : y_hold;
  assign pop       = gap_valid && gap_ready;
  // Dropping game_run kills the push in flight, so no overflow can come from it.
  assign push_en   = (state == PUSH) && game_run;
  // A full FIFO still takes the push when the head leaves on the same edge.
  assign push_ok   = push_en && ((gap_count != FULL_CNT) || pop);
  assign drop_evt  = push_en && !push_ok;

  // Spawn sequencer: frame pacing, draw / range check / retry, then push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= 8'd0;
      retry_cnt <= 8'd0;
      gap_lat   <= 5'd0;
    end else if (!game_run) begin
      state     <= IDLE;
      frame_cnt <= 8'd0;
      retry_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          frame_cnt <= 8'd0;
          retry_cnt <= 8'd0;
          state     <= WAIT;
        end
        WAIT: begin
          if (frame_tick) begin
            if (frame_cnt == LAST_FRAME) begin
              frame_cnt <= 8'd0;
              state     <= DRAW;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        DRAW: state <= CHECK;
        CHECK: begin
          if (in_range) begin
            gap_lat <= lfsr_data;
            state   <= PUSH;
          end else if (retry_cnt < RETRY_LIM) begin
            retry_cnt <= retry_cnt + 8'd1;
            state     <= DRAW;
          end else begin
            gap_lat <= (lfsr_data < GMIN) ? GMIN : GMAX;
            state   <= PUSH;
          end
        end
        PUSH: begin
          retry_cnt <= 8'd0;
          state     <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents are only observed through valid entries, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= gap_lat;
  end

  // FIFO pointers and occupancy, flushed whenever the game stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      gap_count <= 3'd0;
    end else if (!game_run) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      gap_count <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   gap_count <= gap_count + 3'd1;
        2'b01:   gap_count <= gap_count - 3'd1;
        default: gap_count <= gap_count;
      endcase
    end
  end

  // Held gap row, overflow pulse and saturating drop counter (survives game stop).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_hold   <= 5'd0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (gap_valid) y_hold <= mem[rd_ptr];
      overflow <= drop_evt;
      if (drop_evt && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pipe_gap_scheduler.sv
// Bench for pipe_gap_scheduler: LFSR stand-in fed from a draw queue, and a
// scoreboard of expected gap rows checked as the consumer pops them.
`timescale 1ns/1ps
module tb_pipe_gap_scheduler;

  localparam int SF   = 4;
  localparam int MAXR = 3;
  localparam logic [4:0] GMIN = 5'd2;
  localparam logic [4:0] GMAX = 5'd25;

  logic       clk = 1'b0;
  logic       rst_n, game_run, frame_tick, gap_ready;
  logic [4:0] lfsr_data;
  logic       lfsr_step, gap_valid, overflow;
  logic [4:0] gap_y;
  logic [2:0] gap_count;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  int steps  = 0;
  int ovf_cnt = 0;
  logic [4:0] exp_q[$];
  logic [4:0] draw_q[$];

  pipe_gap_scheduler #(.SPAWN_FRAMES(SF), .GAP_MIN(2), .GAP_MAX(25), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst_n(rst_n), .game_run(game_run), .frame_tick(frame_tick),
    .lfsr_data(lfsr_data), .lfsr_step(lfsr_step), .gap_valid(gap_valid),
    .gap_ready(gap_ready), .gap_y(gap_y), .gap_count(gap_count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // LFSR stand-in: each step counted; next queued value appears after the step edge.
  initial forever begin
    @(negedge clk);
    if (lfsr_step === 1'b1) begin
      steps++;
      if (draw_q.size() > 0) begin
        @(posedge clk);
        #1 lfsr_data = draw_q.pop_front();
      end
    end
  end

  // Consumer side: compare every popped head against the scoreboard, count overflows.
  initial forever begin
    @(negedge clk);
    if (overflow === 1'b1) ovf_cnt++;
    if (gap_valid === 1'b1 && gap_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got gap_y=%0d, expected no entry", gap_y);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (gap_y !== e) begin
          errors++;
          $display("FAIL pop_order: got gap_y=%0d, expected %0d", gap_y, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    cyc(n);
    frame_tick = 1'b0;
  endtask

  task automatic spawn();
    ticks(SF);
    cyc(10);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [4:0] model_draw(input logic [4:0] a, b, c, d, output int n);
    logic [4:0] s [4];
    s = '{a, b, c, d};
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n = i + 1;
      if (s[i] >= GMIN && s[i] <= GMAX) return s[i];
      if (i == MAXR) return (s[i] < GMIN) ? GMIN : GMAX;
    end
    return GMAX;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; game_run = 1'b0; frame_tick = 1'b0; gap_ready = 1'b0; lfsr_data = 5'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gap_valid", gap_valid, 0);
    chk("rst_gap_count", gap_count, 0);
    chk("rst_gap_y", gap_y, 0);
    chk("rst_lfsr_step", lfsr_step, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    cyc(2);
    rst_n = 1'b1;
    game_run = 1'b1;
    cyc(2);
  endtask

  task automatic test_basic();
    lfsr_data = 5'd10;
    steps = 0;
    exp_q.push_back(5'd10);
    ticks(SF);
    chk("latency_e0", gap_valid, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      chk($sformatf("latency_e%0d", k), gap_valid, (k == 3) ? 1 : 0);
    end
    chk("basic_steps", steps, 1);
    chk("basic_gap_y", gap_y, 10);
    chk("basic_count", gap_count, 1);
    cyc(4);
    chk("basic_steps_after", steps, 1);
    gap_ready = 1'b1;
    cyc(1);
    gap_ready = 1'b0;
    chk("basic_drained", gap_count, 0);
    chk("basic_hold_y", gap_y, 10);
  endtask

  task automatic test_retry_clamp();
    logic [4:0] seqs [6][4];
    logic [4:0] e;
    int n;
    seqs = '{'{5'd2, 5'd0, 5'd0, 5'd0}, '{5'd25, 5'd0, 5'd0, 5'd0},
             '{5'd1, 5'd26, 5'd0, 5'd24}, '{5'd30, 5'd30, 5'd30, 5'd30},
             '{5'd0, 5'd0, 5'd0, 5'd0}, '{5'd26, 5'd1, 5'd31, 5'd1}};
    gap_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = model_draw(seqs[i][0], seqs[i][1], seqs[i][2], seqs[i][3], n);
      steps = 0;
      for (int j = 0; j < 4; j++) draw_q.push_back(seqs[i][j]);
      exp_q.push_back(e);
      spawn();
      draw_q.delete();
      chk($sformatf("retry_steps_%0d", i), steps, n);
      chk($sformatf("retry_popped_%0d", i), exp_q.size(), 0);
    end
    gap_ready = 1'b0;
  endtask

  task automatic test_tick_ignore();
    gap_ready = 1'b1;
    lfsr_data = 5'd9;
    steps = 0;
    exp_q.push_back(5'd9);
    ticks(SF + 3);
    cyc(6);
    chk("ign_first_spawn", steps, 1);
    ticks(SF - 1);
    cyc(10);
    chk("ign_no_early_spawn", steps, 1);
    exp_q.push_back(5'd9);
    ticks(1);
    cyc(10);
    chk("ign_second_spawn", steps, 2);
    chk("ign_popped", exp_q.size(), 0);
    gap_ready = 1'b0;
  endtask

  task automatic test_overflow();
    gap_ready = 1'b0;
    ovf_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      lfsr_data = 5'(11 + i);
      if (i < 4) exp_q.push_back(5'(11 + i));
      spawn();
    end
    chk("ovf_count_full", gap_count, 4);
    chk("ovf_pulses_1", ovf_cnt, 1);
    chk("ovf_drop_1", drop_cnt, 1);
    for (int i = 0; i < 300; i++) spawn();
    chk("ovf_drop_sat", drop_cnt, 255);
    chk("ovf_pulses_301", ovf_cnt, 301);
    chk("ovf_count_still_full", gap_count, 4);
  endtask

  task automatic test_back_to_back();
    int ovf0;
    ovf0 = ovf_cnt;
    lfsr_data = 5'd20;
    exp_q.push_back(5'd20);
    ticks(SF);
    cyc(2);
    gap_ready = 1'b1;
    cyc(1);
    gap_ready = 1'b0;
    chk("b2b_count_kept", gap_count, 4);
    chk("b2b_no_overflow", overflow, 0);
    cyc(4);
    chk("b2b_no_ovf_pulse", ovf_cnt, ovf0);
    gap_ready = 1'b1;
    cyc(6);
    chk("b2b_drained", gap_count, 0);
    for (int i = 0; i < 3; i++) begin
      lfsr_data = 5'(21 + i);
      exp_q.push_back(5'(21 + i));
      spawn();
    end
    gap_ready = 1'b0;
    chk("b2b_all_popped", exp_q.size(), 0);
  endtask

  task automatic test_run_drop();
    int ovf0;
    gap_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lfsr_data = 5'(5 + i);
      exp_q.push_back(5'(5 + i));
      spawn();
    end
    chk("run_queued", gap_count, 3);
    steps = 0;
    ovf0 = ovf_cnt;
    lfsr_data = 5'd8;
    ticks(SF);
    cyc(1);
    game_run = 1'b0;
    cyc(1);
    chk("run_flush_valid", gap_valid, 0);
    chk("run_flush_count", gap_count, 0);
    cyc(3);
    chk("run_no_push", gap_count, 0);
    chk("run_no_ovf", ovf_cnt, ovf0);
    chk("run_one_draw", steps, 1);
    exp_q.delete();
    game_run = 1'b1;
    cyc(2);
    steps = 0;
    ticks(SF - 1);
    cyc(10);
    chk("run_restart_early", steps, 0);
    exp_q.push_back(5'd8);
    ticks(1);
    cyc(10);
    chk("run_restart_step", steps, 1);
    chk("run_restart_count", gap_count, 1);
    chk("run_restart_y", gap_y, 8);
    gap_ready = 1'b1;
    cyc(2);
    gap_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int ovf0;
    gap_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lfsr_data = 5'(3 + i);
      exp_q.push_back(5'(3 + i));
      spawn();
    end
    chk("arst_queued", gap_count, 2);
    lfsr_data = 5'd5;
    ticks(SF);
    chk("arst_in_draw", lfsr_step, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gap_valid", gap_valid, 0);
    chk("arst_gap_count", gap_count, 0);
    chk("arst_gap_y", gap_y, 0);
    chk("arst_lfsr_step", lfsr_step, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    exp_q.delete();
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    steps = 0;
    ovf0 = ovf_cnt;
    cyc(8);
    chk("arst_no_step", steps, 0);
    chk("arst_no_ovf", ovf_cnt, ovf0);
    chk("arst_empty", gap_valid, 0);
    ticks(SF - 1);
    cyc(10);
    chk("arst_early", steps, 0);
    exp_q.push_back(5'd5);
    ticks(1);
    cyc(10);
    chk("arst_spawn", steps, 1);
    chk("arst_count", gap_count, 1);
    gap_ready = 1'b1;
    cyc(2);
    gap_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retry_clamp();
    test_tick_ignore();
    test_overflow();
    test_back_to_back();
    test_run_drop();
    test_async_reset();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_gap_scheduler.md
PIPE_GAP_SCHEDULER -- requirements
Module: pipe_gap_scheduler

Interface
REQ-001 The block SHALL have parameter SPAWN_FRAMES, default 60, giving frames between pipe spawns (range 2..255).
REQ-002 The block SHALL have parameter GAP_MIN, default 2, giving the lowest legal gap row (5-bit).
REQ-003 The block SHALL have parameter GAP_MAX, default 25, giving the highest legal gap row (5-bit, GAP_MAX >= GAP_MIN).
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, giving the number of redraws allowed after an out-of-range draw.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 The block SHALL have port game_run, input, 1 bit, level; high while the game is in play.
REQ-008 The block SHALL have port frame_tick, input, 1 bit, one-cycle pulse per video frame.
REQ-009 The block SHALL have port lfsr_data, input, 5 bits, current fibonacci_lfsr output.
REQ-010 The block SHALL have port lfsr_step, output, 1 bit, one-cycle enable that advances the LFSR.
REQ-011 The block SHALL have port gap_valid, output, 1 bit, FIFO not empty.
REQ-012 The block SHALL have port gap_ready, input, 1 bit, consumer accepts the head entry.
REQ-013 The block SHALL have port gap_y, output, 5 bits, head-of-FIFO gap row.
REQ-014 The block SHALL have port gap_count, output, 3 bits, FIFO occupancy 0..4.
REQ-015 The block SHALL have port overflow, output, 1 bit, one-cycle pulse when a spawn is dropped.
REQ-016 The block SHALL have port drop_cnt, output, 8 bits, saturating count of dropped spawns.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, DRAW, CHECK and PUSH.
REQ-018 IDLE: frame counter held at 0 and retry counter held at 0; on game_run=1 the FSM SHALL go to WAIT.
REQ-019 WAIT: each frame_tick SHALL increment the frame counter.
REQ-020 WAIT, on a frame_tick with counter = SPAWN_FRAMES-1: the counter SHALL clear to 0 and the FSM SHALL go to DRAW.
REQ-021 DRAW SHALL last one cycle, assert lfsr_step=1 (the only state that does) and go to CHECK.
REQ-022 CHECK SHALL sample lfsr_data and compare it against the legal range.
REQ-023 CHECK, in range (GAP_MIN <= v <= GAP_MAX): v SHALL be latched and the FSM SHALL go to PUSH.
REQ-024 CHECK, out of range with retry < MAX_RETRY: retry SHALL increment and the FSM SHALL go to DRAW.
REQ-025 CHECK, out of range with retry = MAX_RETRY: the latched value SHALL be clamped (v<GAP_MIN -> GAP_MIN, v>GAP_MAX -> GAP_MAX) and the FSM SHALL go to PUSH.
REQ-026 PUSH SHALL write the latched value to the FIFO, clear retry and go to WAIT, all in one cycle.
REQ-027 frame_ticks arriving during DRAW/CHECK/PUSH SHALL be ignored (not counted).
REQ-028 Latency: with an in-range first draw and the FIFO empty, gap_valid SHALL rise 3 clock edges after the edge that samples the final frame_tick.
REQ-029 The FIFO SHALL have 4 entries and be first-word-fall-through: gap_y shows the head whenever gap_valid=1.
REQ-030 A pop SHALL occur on any edge where gap_valid=1 and gap_ready=1.
REQ-031 A PUSH SHALL be accepted if gap_count<4, or if gap_count=4 and a pop occurs on the same edge; a simultaneous push and pop SHALL leave gap_count unchanged.
REQ-032 A PUSH that is not accepted SHALL drop the value, pulse overflow for exactly 1 cycle and increment drop_cnt, saturating at 255.
REQ-033 gap_y SHALL hold its last value when the FIFO is empty; the consumer SHALL ignore it while gap_valid=0.
REQ-034 game_run=0 in any state SHALL force IDLE on the next edge, flush the FIFO (gap_count=0), abandon any pending draw and produce no overflow pulse; drop_cnt SHALL be retained.
REQ-035 Pointer wrap-around SHALL be modulo 4 with no lost or duplicated entries.

Reset
REQ-036 rst_n=0 SHALL immediately force: state IDLE, frame and retry counters 0, FIFO pointers 0, gap_count=0, gap_valid=0, gap_y=0, lfsr_step=0, overflow=0, drop_cnt=0.
REQ-037 Reset asserted mid-operation (any state, FIFO non-empty) SHALL discard all contents, with no pulse on any output during or after release.
REQ-038 After rst_n rises, the first spawn SHALL need a full SPAWN_FRAMES frame_ticks counted from WAIT.

Verification
REQ-039 SPAWN_FRAMES=4, lfsr_data=10, gap_ready=0, game_run=1: 4 frame_ticks -> exactly one lfsr_step pulse; gap_valid=1, gap_y=10, gap_count=1.
REQ-040 lfsr_data held at 30: one spawn -> 4 lfsr_step pulses (1+MAX_RETRY), gap_y=25; lfsr_data held at 0 -> gap_y=2.
REQ-041 gap_ready=0, 5 spawns -> gap_count=4, one overflow pulse on the 5th, drop_cnt=1; 300 further drops -> drop_cnt=255.
REQ-042 FIFO full with gap_ready=1 on the PUSH edge -> no overflow, gap_count stays 4; pop order matches push order across 6+ entries (wrap).
REQ-043 game_run dropped in CHECK with 3 entries queued -> next cycle IDLE, gap_valid=0, no push; restart needs 4 ticks.
REQ-044 rst_n pulsed low for 1 cycle during DRAW, asynchronous to clk -> all outputs 0 immediately; no lfsr_step after release until 4 new ticks.
